mac_row: RTL and testbench
==========================

# mac_row

Weight-stationary row of `col` multiply-accumulate tiles feeding the output-stationary accumulation stage of the array. Weights and activations are streamed in on one west-edge bus. Partial sums enter from the north and leave to the south, one lane per tile. Each tile holds one signed weight, then multiplies passing unsigned activations and adds the incoming partial sum. The per-lane results go to the next row or to the accumulation buffer.

## Interface
- `bw`, 4, activation/weight width
- `psum_bw`, 16, partial-sum width
- `col`, 8, tiles per row

- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_w`  in  bw  west data: weights during load, unsigned activations during execute
- `inst_w`  in  2  bit0 = load, bit1 = execute
- `in_n`  in  psum_bw*col  north partial sums, lane i = bits [psum_bw*(i+1)-1 : psum_bw*i]
- `out_s`  out  psum_bw*col  south partial sums, same lane packing
- `valid`  out  col  valid[i] high when lane i of out_s is a result

## Operation
- Per-tile registers:
  - `a_q` (bw), activation
  - `b_q` (bw, signed), weight
  - `c_q` (psum_bw), partial sum
  - `inst_q` (2)
  - `load_ready_q` (1)
- Chaining: tile 0 takes in_w/inst_w. Tile i takes `a_q`/`inst_q` of tile i-1.
- Tile state machine:
  - EMPTY (load_ready_q=1) → LOADED on the first cycle its inst bit0 = 1. In that cycle `b_q` <= input data and `load_ready_q` <= 0.
  - LOADED → EMPTY only via reset. Reloading requires reset.
  - In LOADED, further inst bit0 cycles do not change `b_q`.
- `inst_q[0]` <= inst bit0 AND NOT load_ready_q (old value). The load token passes east only after the tile holds its weight.
- `inst_q[1]` <= inst bit1, every cycle.
- `a_q` <= input data when either inst bit is 1, else hold.
- `c_q` <= lane i of in_n when inst bit1 = 1, else hold.
- Arithmetic, combinational per lane:
  - out_s lane i = sext(signed({1'b0,a_q}) * b_q) + c_q, truncated to psum_bw.
  - Two's-complement wrap; no saturation.
- valid[i] = tile i `inst_q[1]`.
- When valid[i]=0, out_s lane i still shows the arithmetic result. Consumers must ignore it.
- Both inst bits set in one cycle is legal:
  - the load updates `b_q`;
  - the execute captures `a_q`/`c_q`;
  - the following cycle's result uses the new `b_q`.
- Reset (async, any time) sets:
  - all `a_q`, `b_q`, `c_q`, `inst_q` to 0;
  - `load_ready_q` to 1 (all tiles EMPTY);
  - valid to 0 and out_s to 0 immediately.

## Timing
- Load:
  - Drive inst_w=2'b01 for `col` consecutive cycles (t0..t0+col-1) with in_w = W0, W1, …, W(col-1).
  - Tile i latches Wi at edge t0+2i.
  - All weights are resident after edge t0+2(col-1).
  - Gaps in the load stream are unsupported.
- Execute:
  - Activation X driven with inst_w=2'b10 at cycle t reaches tile i at edge t+i.
  - valid[i] rises at t+i+1 with lane i = X*Wi + in_n lane i.
  - in_n lane i must be presented at cycle t+i (diagonally skewed).
- Throughput: one activation per cycle; back-to-back execute keeps valid[i] continuously high.
- Latency per lane: i+1 cycles.

## Structure
- Shared package `mac_pkg`:
  - `BW`=4, `PSUM_BW`=16, `COL`=8;
  - `INST_LOAD`=0, `INST_EXEC`=1 bit indices;
  - 2-bit `inst_t` typedef.
- Sub-module `mac_tile`: the registers, state machine and arithmetic above. It has ports `clk`, `reset_n`, `in_w`, `inst_w`, `in_n`, `out_e`, `inst_e`, `out_s`, `valid`.
- `mac_row` is a generate chain of `col` `mac_tile` instances plus bus packing.

## Test plan
- Reset, then load W = 1,2,…,8 over 8 cycles → after 15 edges each tile i holds i+1.
  - A 9th load cycle with in_w=4'hF leaves every `b_q` unchanged.
- Load W0=4'b1101 (-3); execute X=5 with in_n lane0=16'd10 → valid[0] high one cycle later, lane0=16'hFFFB.
- Wrap: W0=7, X=15, in_n lane0=16'h7FFF → lane0=16'h8068, no saturation.
- Full row, W all 2:
  - Stream X=1..4 back-to-back, skewed in_n=0.
  - Lane i outputs 2,4,6,8 on edges t+i+1…t+i+4.
  - valid[i] is high for exactly 4 cycles.
- inst_w=2'b11 on tile 0's first cycle with in_w=3, in_n lane0=1 → W0=3, lane0=10 next cycle.
- Assert reset_n low mid-execute:
  - valid and out_s go to 0 without a clock edge;
  - all tiles are EMPTY;
  - a fresh load of W=4 then X=3 gives lane0=12.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants, types and the per-lane multiply-accumulate helper for the MAC row.
package mac_pkg;

    localparam int BW        = 4;
    localparam int PSUM_BW   = 16;
    localparam int COL       = 8;
    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;

    typedef logic [1:0] inst_t;

    typedef enum logic {
        TILE_LOADED = 1'b0,
        TILE_EMPTY  = 1'b1
    } tile_state_t;

    // Zero-extended activation times signed weight, sign-extended and added with wrap.
    function automatic logic [PSUM_BW-1:0] mac_fn(
        input logic        [BW-1:0]      a,
        input logic signed [BW-1:0]      b,
        input logic        [PSUM_BW-1:0] c
    );
        logic signed [BW:0]      a_ext;
        logic signed [PSUM_BW-1:0] prod;
        a_ext = $signed({1'b0, a});
        prod  = PSUM_BW'(a_ext) * PSUM_BW'(b);
        return prod + c;
    endfunction

endpackage

// File: rtl/mac_row_if.sv
// West/north inputs and south outputs of one MAC row, bundled for the row and its driver.
interface mac_row_if;
    import mac_pkg::*;

    logic [BW-1:0]          in_w;
    inst_t                  inst_w;
    logic [PSUM_BW*COL-1:0] in_n;
    logic [PSUM_BW*COL-1:0] out_s;
    logic [COL-1:0]         valid;

    modport master (
        output in_w, inst_w, in_n,
        input  out_s, valid
    );

    modport slave (
        input  in_w, inst_w, in_n,
        output out_s, valid
    );

endinterface

// File: rtl/mac_tile.sv
// One weight-stationary tile: holds a signed weight once loaded, forwards activation and
// instruction east, and presents activation*weight + north partial sum to the south.
module mac_tile
    import mac_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [BW-1:0]      in_w,
    input  inst_t              inst_w,
    input  logic [PSUM_BW-1:0] in_n,
    output logic [BW-1:0]      out_e,
    output inst_t              inst_e,
    output logic [PSUM_BW-1:0] out_s,
    output logic               valid
);

    tile_state_t          state_q, state_d;
    logic [BW-1:0]        a_q, a_d;
    logic signed [BW-1:0] b_q, b_d;
    logic [PSUM_BW-1:0]   c_q, c_d;
    inst_t                inst_q, inst_d;
    logic                 load_ready_s;

    // The EMPTY state is the tile's load-ready flag.
    assign load_ready_s = (state_q == TILE_EMPTY);

    // Next-state and datapath capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        inst_d  = 2'b00;

        case (state_q)
            TILE_EMPTY: begin
                if (inst_w[INST_LOAD]) begin
                    state_d = TILE_LOADED;
                    b_d     = in_w;
                end else begin
                    state_d = TILE_EMPTY;
                end
            end
            TILE_LOADED: state_d = TILE_LOADED;
            default:     state_d = TILE_EMPTY;
        endcase

        // Load token moves east only once this tile already holds its weight.
        inst_d[INST_LOAD] = inst_w[INST_LOAD] & ~load_ready_s;
        inst_d[INST_EXEC] = inst_w[INST_EXEC];

        if (|inst_w) begin
            a_d = in_w;
        end else begin
            a_d = a_q;
        end

        if (inst_w[INST_EXEC]) begin
            c_d = in_n;
        end else begin
            c_d = c_q;
        end
    end

    // Tile registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TILE_EMPTY;
            a_q     <= {BW{1'b0}};
            b_q     <= {BW{1'b0}};
            c_q     <= {PSUM_BW{1'b0}};
            inst_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            inst_q  <= inst_d;
        end
    end

    assign out_e  = a_q;
    assign inst_e = inst_q;
    assign out_s  = mac_fn(a_q, b_q, c_q);
    assign valid  = inst_q[INST_EXEC];

endmodule

// File: rtl/mac_row.sv
// Row of COL MAC tiles chained west to east; each tile owns one north/south lane.
module mac_row
    import mac_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    mac_row_if.slave  bus
);

    logic [BW-1:0]                a_chain_s    [COL+1];
    inst_t                        inst_chain_s [COL+1];
    logic [COL-1:0][PSUM_BW-1:0]  in_lane_s;
    logic [COL-1:0][PSUM_BW-1:0]  out_lane_s;
    logic [COL-1:0]               valid_s;
    logic                         unused_tail_s;

    assign a_chain_s[0]    = bus.in_w;
    assign inst_chain_s[0] = bus.inst_w;
    assign in_lane_s       = bus.in_n;
    assign bus.out_s       = out_lane_s;
    assign bus.valid       = valid_s;
    assign unused_tail_s   = ^{a_chain_s[COL], inst_chain_s[COL]};

    for (genvar g = 0; g < COL; g++) begin : g_tile
        mac_tile u_tile (
            .clk     (clk),
            .reset_n (reset_n),
            .in_w    (a_chain_s[g]),
            .inst_w  (inst_chain_s[g]),
            .in_n    (in_lane_s[g]),
            .out_e   (a_chain_s[g+1]),
            .inst_e  (inst_chain_s[g+1]),
            .out_s   (out_lane_s[g]),
            .valid   (valid_s[g])
        );
    end

endmodule

// File: tb/tb_mac_row.sv
// Randomised and directed bench for mac_row with a per-lane expected-result scoreboard.
module tb_mac_row;
    import mac_pkg::*;

    logic clk;
    logic reset_n;

    mac_row_if bus ();

    mac_row dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [PSUM_BW-1:0] exp_q [COL][$];
    int                 w_model [COL];
    int                 load_cnt;

    logic [BW-1:0]      act_buf [16];
    logic [PSUM_BW-1:0] nbuf    [16][COL];
    logic [BW-1:0]      wbuf    [16];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, expv);
        end
    endtask

    // Reference: after reset, the j-th load word of the stream becomes tile j's weight.
    task automatic model_load(input logic [BW-1:0] d);
        if (load_cnt < COL) w_model[load_cnt] = int'($signed(d));
        load_cnt++;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            bus.inst_w = 2'b00;
            bus.in_w   = 4'($urandom);
            bus.in_n   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
    endtask

    task automatic load_w(input int n);
        for (int j = 0; j < n; j++) begin
            bus.inst_w = 2'b01;
            bus.in_w   = wbuf[j];
            bus.in_n   = {$urandom, $urandom, $urandom, $urandom};
            model_load(wbuf[j]);
            @(posedge clk); #1;
        end
    endtask

    // Streams act_buf[0..len-1], skewing north sums so lane i sees nbuf[k][i] at cycle k+i.
    task automatic run_wave(input int len, input bit also_load, input int abort_at);
        inst_t inst;
        int    e;
        logic [31:0] ev;
        for (int c = 0; c < len + COL; c++) begin
            if (c == abort_at) return;
            inst = 2'b00;
            if (c < len) inst[INST_EXEC] = 1'b1;
            if (c == 0 && also_load) inst[INST_LOAD] = 1'b1;
            bus.inst_w = inst;
            bus.in_w   = (c < len) ? act_buf[c] : 4'($urandom);
            for (int i = 0; i < COL; i++) begin
                if (c - i >= 0 && c - i < len) bus.in_n[i*PSUM_BW +: PSUM_BW] = nbuf[c-i][i];
                else                           bus.in_n[i*PSUM_BW +: PSUM_BW] = 16'($urandom);
            end
            if (inst[INST_LOAD]) model_load(bus.in_w);
            if (c < len) begin
                for (int i = 0; i < COL; i++) begin
                    e  = int'(act_buf[c]) * w_model[i] + int'(nbuf[c][i]);
                    ev = e;
                    exp_q[i].push_back(ev[PSUM_BW-1:0]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input bit check_drained);
        if (check_drained)
            for (int i = 0; i < COL; i++)
                chk($sformatf("pending_lane%0d", i), 128'(exp_q[i].size()), 128'd0);
        reset_n = 1'b0;
        #1;
        chk("reset_valid", 128'(bus.valid), 128'd0);
        chk("reset_out_s", 128'(bus.out_s), 128'd0);
        for (int i = 0; i < COL; i++) begin
            exp_q[i].delete();
            w_model[i] = 0;
        end
        load_cnt   = 0;
        bus.inst_w = 2'b00;
        bus.in_w   = 4'd0;
        bus.in_n   = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic clear_wave();
        for (int k = 0; k < 16; k++) begin
            act_buf[k] = 4'd0;
            for (int i = 0; i < COL; i++) nbuf[k][i] = 16'd0;
        end
    endtask

    // Scoreboard monitor: every valid lane must match the oldest expectation for that lane.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < COL; i++) begin
                if (bus.valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_valid lane%0d: got %h expected none", i,
                                 bus.out_s[i*PSUM_BW +: PSUM_BW]);
                    end else begin
                        chk($sformatf("lane%0d", i),
                            128'(bus.out_s[i*PSUM_BW +: PSUM_BW]), 128'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        bus.inst_w = 2'b00;
        bus.in_w   = 4'd0;
        bus.in_n   = '0;
        load_cnt   = 0;
        do_reset(1'b0);

        // Weights 1..8 plus a surplus load word that must be ignored.
        for (int j = 0; j < COL; j++) wbuf[j] = 4'(j + 1);
        wbuf[COL] = 4'hF;
        load_w(COL + 1);
        clear_wave();
        act_buf[0] = 4'd1;
        run_wave(1, 1'b0, -1);
        clear_wave();
        for (int k = 0; k < 3; k++) begin
            act_buf[k] = 4'($urandom);
            for (int i = 0; i < COL; i++) nbuf[k][i] = 16'($urandom);
        end
        run_wave(3, 1'b0, -1);
        idle(2);

        // Negative weight.
        do_reset(1'b1);
        wbuf[0] = 4'b1101;
        load_w(1);
        clear_wave();
        act_buf[0] = 4'd5;
        nbuf[0][0] = 16'd10;
        run_wave(1, 1'b0, -1);
        idle(2);

        // Two's-complement wrap.
        do_reset(1'b1);
        wbuf[0] = 4'd7;
        load_w(1);
        clear_wave();
        act_buf[0] = 4'd15;
        nbuf[0][0] = 16'h7FFF;
        run_wave(1, 1'b0, -1);
        idle(2);

        // Full row, all weights 2, back-to-back activations 1..4.
        do_reset(1'b1);
        for (int j = 0; j < COL; j++) wbuf[j] = 4'd2;
        load_w(COL);
        clear_wave();
        for (int k = 0; k < 4; k++) act_buf[k] = 4'(k + 1);
        run_wave(4, 1'b0, -1);
        idle(2);

        // Load and execute in the same cycle.
        do_reset(1'b1);
        clear_wave();
        act_buf[0] = 4'd3;
        nbuf[0][0] = 16'd1;
        run_wave(1, 1'b1, -1);
        idle(2);

        // Randomised rows.
        for (int r = 0; r < 6; r++) begin
            int len;
            do_reset(1'b1);
            for (int j = 0; j < COL + 1; j++) wbuf[j] = 4'($urandom);
            load_w(COL + int'($urandom_range(0, 1)));
            len = int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) begin
                act_buf[k] = 4'($urandom);
                for (int i = 0; i < COL; i++) nbuf[k][i] = 16'($urandom);
            end
            run_wave(len, 1'b0, -1);
            idle(int'($urandom_range(2, 4)));
        end

        // Asynchronous reset in the middle of execution.
        do_reset(1'b1);
        for (int j = 0; j < COL; j++) wbuf[j] = 4'($urandom);
        load_w(COL);
        for (int k = 0; k < 6; k++) begin
            act_buf[k] = 4'($urandom_range(1, 15));
            for (int i = 0; i < COL; i++) nbuf[k][i] = 16'($urandom);
        end
        run_wave(6, 1'b0, 3);
        #1;
        chk("valid_before_reset", 128'(bus.valid != '0), 128'd1);
        do_reset(1'b0);
        wbuf[0] = 4'd4;
        load_w(1);
        clear_wave();
        act_buf[0] = 4'd3;
        run_wave(1, 1'b0, -1);
        idle(2);

        for (int i = 0; i < COL; i++)
            chk($sformatf("final_pending_lane%0d", i), 128'(exp_q[i].size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
